// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX FIFO write-side arbiter.
//   arb_state_e : arbiter FSM states (IDLE, owned by src0, owned by src1)
//   SRC0 / SRC1 : source index constants used by the priority pointer and the pick logic
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational 2-way round-robin pick.
//   valid[1:0] : request from src1 (bit 1) and src0 (bit 0)
//   prio       : source that wins when both request (SRC0 or SRC1)
//   any        : at least one source requests
//   sel        : chosen source index (only meaningful when any=1)
module arb_rr_pick
  import uart_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       any,
  output logic       sel
);

  always_comb begin
    any = |valid;
    if (&valid) begin
      sel = prio;
    end else begin
      // A lone requester wins regardless of the pointer.
      sel = valid[SRC1] ? SRC1 : SRC0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_arbiter.sv
// Shares the UART TX byte FIFO write port between two message sources. Whole messages
// are granted round-robin so bytes of different messages never interleave in the FIFO.
//
// Handshake: a byte moves from source n to the FIFO when sN_valid & sN_ready are both
// high at a rising clk edge; on that same edge fifo_push is high and fifo_wdata carries
// the byte. Only the owning source ever sees ready, and only while fifo_full=0. A source
// holding valid keeps its data and last stable until the byte is taken.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s0_valid/data/last    source 0 byte offer, s0_ready = accepted this cycle
//   s1_valid/data/last    source 1 byte offer, s1_ready = accepted this cycle
//   fifo_full             FIFO full flag
//   fifo_push, fifo_wdata FIFO write strobe and data
//   grant                 one-hot owner: 01 = src0, 10 = src1, 00 = none
//   burst_err             1-cycle pulse after a grant is force-released at MAX_BURST
//   dbg_state             raw FSM state for observation
module uart_tx_fifo_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_last,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_last,
  output logic                  s1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [1:0]            grant,
  output logic                  burst_err,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e            state_q, state_d;
  logic                  prio_q, prio_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  burst_err_q, burst_err_d;

  logic                  pick_any, pick_sel;
  logic                  cur_valid, cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  xfer, at_max, rel;

  arb_rr_pick u_pick (
    .valid ({s1_valid, s0_valid}),
    .prio  (prio_q),
    .any   (pick_any),
    .sel   (pick_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= SRC0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  // Owner data path: the owning source is muxed straight to the FIFO with no latency.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    case (state_q)
      ST_OWN0: begin
        cur_valid = s0_valid;
        cur_last  = s0_last;
        cur_data  = s0_data;
        s0_ready  = ~fifo_full;
      end
      ST_OWN1: begin
        cur_valid = s1_valid;
        cur_last  = s1_last;
        cur_data  = s1_data;
        s1_ready  = ~fifo_full;
      end
      default: ;
    endcase
    xfer   = cur_valid & ~fifo_full;
    // This byte completes the allowed burst.
    at_max = (cnt_q + CNT_ONE) == CNT_MAX;
    rel    = xfer & (cur_last | at_max);
  end

  // Next-state, counter, priority pointer and error pulse.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    burst_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = pick_sel ? ST_OWN1 : ST_OWN0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (rel) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          // Hand priority to the other source so the next contention is fair.
          prio_d      = (state_q == ST_OWN0) ? SRC1 : SRC0;
          // A last byte that lands exactly on the limit is a normal end of message.
          burst_err_d = ~cur_last;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign fifo_push  = xfer;
  assign fifo_wdata = cur_data;
  assign grant      = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign burst_err  = burst_err_q;
  assign dbg_state  = state_q;

endmodule
